hs_responder: RTL and testbench

//   Responder side of the req/ack handshake. It accepts a request and its data

---
 rtl/hs_responder_if.sv | 23 ++
 rtl/hs_responder.sv | 108 ++++++++++
 tb/tb_hs_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/hs_responder_if.sv
// Request/acknowledge handshake bundle between a requesting master and the responder.
interface hs_responder_if #(
  parameter int DATA_W = 8
);
  logic              req;
  logic [DATA_W-1:0] req_data;
  logic              err_clr;
  logic              ack;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              error_state;
  logic [3:0]        counter;

  modport master (
    output req, req_data, err_clr,
    input  ack, valid, data, error_state, counter
  );

  modport slave (
    input  req, req_data, err_clr,
    output ack, valid, data, error_state, counter
  );
endinterface

// File: rtl/hs_responder.sv
// Handshake responder: accepts a non-zero request word, returns it with ack/valid after LAT cycles,
// and latches protocol violations (zero payload, abandoned request) into a sticky error state.
//
//   state | meaning
//   IDLE  | waiting for req; a non-zero req_data is captured on the accepting edge
//   WAIT  | latency countdown in progress; req must stay high
//   ACK   | one-cycle ack/valid with the captured word on data
//   ERR   | sticky protocol error; left only via err_clr with req low
module hs_responder #(
  parameter int DATA_W = 8,
  parameter int LAT    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  hs_responder_if.slave bus
);

  if (LAT < 1 || LAT > 15) begin : g_lat_range
    $error("hs_responder: LAT must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_e;

  localparam logic [3:0] CNT_LAST = 4'(LAT - 1);
  localparam logic [3:0] CNT_MAX  = 4'd14;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (bus.req_data != '0) begin
            buf_d = bus.req_data;
            if (LAT == 1) begin
              cnt_d   = 4'd0;
              state_d = ACK;
            end else begin
              cnt_d   = 4'd1;
              state_d = WAIT;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = ERR;
          end
        end
      end
      WAIT: begin
        if (!bus.req) begin
          state_d = ERR;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ACK;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      ERR: begin
        // err_clr is only honoured once the master has released req
        if (bus.err_clr && !bus.req) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe
    ack_d  = (state_d == ACK);
    err_d  = (state_d == ERR);
    data_d = (state_d == ACK) ? buf_d : data_q;
  end

  assign bus.ack         = ack_q;
  assign bus.valid       = ack_q;
  assign bus.data        = data_q;
  assign bus.error_state = err_q;
  assign bus.counter     = cnt_q;

endmodule

// File: tb/tb_hs_responder.sv
// Bench for hs_responder: three instances (LAT = 1, 2, 5) with a queue scoreboard per instance.
module tb_hs_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] d;
    int         e;
  } exp_t;

  exp_t sbq[3][$];

  logic       req_a [3];
  logic [7:0] rd_a  [3];
  logic       clr_a [3];
  logic       ack_a [3];
  logic       val_a [3];
  logic [7:0] dat_a [3];
  logic       err_a [3];
  logic [3:0] cnt_a [3];

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 5;
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, i, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hs_responder_if #(.DATA_W(8)) u_if ();

    hs_responder #(.DATA_W(8), .LAT((g == 0) ? 1 : (g == 1) ? 2 : 5)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
    );

    assign u_if.req      = req_a[g];
    assign u_if.req_data = rd_a[g];
    assign u_if.err_clr  = clr_a[g];
    assign ack_a[g]      = u_if.ack;
    assign val_a[g]      = u_if.valid;
    assign dat_a[g]      = u_if.data;
    assign err_a[g]      = u_if.error_state;
    assign cnt_a[g]      = u_if.counter;

    always @(negedge clk) begin
      if (rst_n && (ack_a[g] || val_a[g])) begin
        exp_t x;
        chk("ack_eq_valid", g, 32'(ack_a[g]), 32'(val_a[g]));
        if (sbq[g].size() == 0) begin
          chk("unexpected_valid", g, 32'(val_a[g]), 32'd0);
        end else begin
          x = sbq[g].pop_front();
          chk("data", g, 32'(dat_a[g]), 32'(x.d));
          chk("ack_edge", g, 32'(edge_cnt), 32'(x.e));
        end
      end
    end
  end

  // Called at a negedge; the request is sampled skip edges after the next one.
  task automatic send(int i, logic [7:0] d, bit keep, int skip);
    exp_t x;
    bit   seen;
    seen     = 1'b0;
    req_a[i] = 1'b1;
    rd_a[i]  = d;
    x.d      = d;
    x.e      = edge_cnt + skip + lat_of(i);
    sbq[i].push_back(x);
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 0 && skip == 0 && lat_of(i) > 1) chk("wait_counter", i, 32'(cnt_a[i]), 32'd1);
      if (ack_a[i]) seen = 1'b1;
    end
    if (!seen) chk("ack_timeout", i, 32'(ack_a[i]), 32'd1);
    if (!keep) req_a[i] = 1'b0;
  endtask

  task automatic zero_req(int i);
    req_a[i] = 1'b1;
    rd_a[i]  = 8'h00;
    @(negedge clk);
    chk("zero_err", i, 32'(err_a[i]), 32'd1);
    chk("zero_cnt", i, 32'(cnt_a[i]), 32'd0);
    chk("zero_novalid", i, 32'(val_a[i]), 32'd0);
    clr_a[i] = 1'b1;
    @(negedge clk);
    chk("clr_with_req", i, 32'(err_a[i]), 32'd1);
    req_a[i] = 1'b0;
    @(negedge clk);
    chk("clr_exit", i, 32'(err_a[i]), 32'd0);
    chk("clr_cnt", i, 32'(cnt_a[i]), 32'd0);
    clr_a[i] = 1'b0;
    send(i, 8'h5E, 1'b0, 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_a[i] = 1'b0;
      rd_a[i]  = 8'h00;
      clr_a[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ack", i, 32'(ack_a[i]), 32'd0);
      chk("rst_valid", i, 32'(val_a[i]), 32'd0);
      chk("rst_err", i, 32'(err_a[i]), 32'd0);
      chk("rst_data", i, 32'(dat_a[i]), 32'd0);
      chk("rst_cnt", i, 32'(cnt_a[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // LAT=2 single request
    send(1, 8'hA5, 1'b0, 0);
    @(negedge clk);
    chk("t1_noerr", 1, 32'(err_a[1]), 32'd0);

    // LAT=1 back-to-back, req held through the ack cycle
    send(0, 8'h11, 1'b1, 0);
    send(0, 8'h22, 1'b0, 1);
    @(negedge clk);
    chk("t2_noerr", 0, 32'(err_a[0]), 32'd0);

    // Zero payload goes to ERR, recovery, then a normal request
    zero_req(0);
    zero_req(1);

    // LAT=5 request abandoned in cycle 2
    req_a[2] = 1'b1;
    rd_a[2]  = 8'h5A;
    @(negedge clk);
    chk("t4_cnt1", 2, 32'(cnt_a[2]), 32'd1);
    @(negedge clk);
    chk("t4_cnt2", 2, 32'(cnt_a[2]), 32'd2);
    req_a[2] = 1'b0;
    @(negedge clk);
    chk("t4_err", 2, 32'(err_a[2]), 32'd1);
    chk("t4_frozen", 2, 32'(cnt_a[2]), 32'd2);
    chk("t4_noack", 2, 32'(ack_a[2]), 32'd0);
    clr_a[2] = 1'b1;
    req_a[2] = 1'b1;
    @(negedge clk);
    chk("t4_clr_ignored", 2, 32'(err_a[2]), 32'd1);
    chk("t4_cnt_hold", 2, 32'(cnt_a[2]), 32'd2);
    req_a[2] = 1'b0;
    @(negedge clk);
    chk("t4_clr_exit", 2, 32'(err_a[2]), 32'd0);
    chk("t4_cnt_clear", 2, 32'(cnt_a[2]), 32'd0);
    clr_a[2] = 1'b0;

    // Async reset while LAT=5 instance is in WAIT
    req_a[2] = 1'b1;
    rd_a[2]  = 8'h3C;
    @(negedge clk);
    chk("t5_wait_cnt", 2, 32'(cnt_a[2]), 32'd1);
    #2;
    rst_n    = 1'b0;
    req_a[2] = 1'b0;
    #1;
    chk("t5_async_cnt", 2, 32'(cnt_a[2]), 32'd0);
    chk("t5_async_ack", 2, 32'(ack_a[2]), 32'd0);
    chk("t5_async_err", 2, 32'(err_a[2]), 32'd0);
    chk("t5_async_data", 1, 32'(dat_a[1]), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    send(2, 8'hC3, 1'b0, 0);

    // Random legal traffic on every instance
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 16; n++) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        send(i, 8'($urandom_range(1, 255)), 1'b0, 0);
      end
    end

    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("queue_empty", i, 32'(sbq[i].size()), 32'd0);
      chk("final_noerr", i, 32'(err_a[i]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
